mini_stream_subsystem: RTL and testbench

MINI_STREAM_SUBSYSTEM -- requirements
Module: mini_stream_subsystem

---
 rtl/mini_stream_subsystem.sv | 170 +++++++++++++++++
 tb/tb_mini_stream_subsystem.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mini_stream_subsystem.sv
// mini_stream_subsystem: a counter feeds a registered ALU stage whose results
// stream into a FIFO. The generator advances only while the FIFO can take both
// the in-flight ALU result and the new one, so no write is ever dropped.
module mini_stream_subsystem #(
  parameter int N        = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [1:0]                 cnt_mode,
  input  logic [N-1:0]               load_val,
  input  logic [N-1:0]               ext_data,
  input  logic [2:0]                 alu_sel,
  input  logic                       fifo_rd,
  input  logic                       err_clr,
  output logic [N-1:0]               fifo_out,
  output logic                       fifo_out_valid,
  output logic                       fifo_empty,
  output logic                       fifo_full,
  output logic                       fifo_almost_full,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       err_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_LOAD = 2'b10,
    MODE_HOLD = 2'b11
  } cnt_mode_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  logic [N-1:0]  cnt_q, cnt_d;
  logic [N-1:0]  alu_reg_q, alu_reg_d;
  logic          alu_valid_q, alu_valid_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  fifo_out_q, fifo_out_d;
  logic          fifo_out_valid_q, fifo_out_valid_d;
  logic          err_q, err_d;

  logic [N-1:0]  mem [DEPTH];

  logic [CW:0]   occ_sum;
  logic          advance;
  logic          wr_en;
  logic          rd_en;
  logic [N-1:0]  alu_result;

  // Status flags come straight from the registered occupancy.
  assign fifo_empty       = (count_q == '0);
  assign fifo_full        = (count_q == CW'(DEPTH));
  assign fifo_almost_full = (count_q >= CW'(AF_LEVEL));
  assign fifo_count       = count_q;
  assign fifo_out         = fifo_out_q;
  assign fifo_out_valid   = fifo_out_valid_q;
  assign err_underflow    = err_q;

  // ALU on the pre-update counter value and the external operand.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    alu_result = '0;
    unique case (alu_op_e'(alu_sel))
      OP_ADD: alu_result = cnt_q + ext_data;
      OP_SUB: alu_result = cnt_q - ext_data;
      OP_AND: alu_result = cnt_q & ext_data;
      OP_OR:  alu_result = cnt_q | ext_data;
      OP_XOR: alu_result = cnt_q ^ ext_data;
      OP_NOT: alu_result = ~cnt_q;
      OP_SHL: alu_result = cnt_q << 1;
      OP_SHR: alu_result = cnt_q >> 1;
      default: alu_result = '0;
    endcase
  end

  // Next-state for generator, FIFO bookkeeping, read port and error flag.
  always_comb begin
    // Advancing reserves a slot for the in-flight result as well as the new one.
    occ_sum          = {1'b0, count_q} + {{CW{1'b0}}, alu_valid_q};
    advance          = enable && (occ_sum < (CW + 1)'(DEPTH));
    wr_en            = alu_valid_q;
    rd_en            = fifo_rd && !fifo_empty;

    cnt_d            = cnt_q;
    alu_reg_d        = alu_reg_q;
    alu_valid_d      = advance;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    fifo_out_d       = fifo_out_q;
    fifo_out_valid_d = rd_en;
    err_d            = err_q;

    if (advance) begin
      alu_reg_d = alu_result;
      unique case (cnt_mode_e'(cnt_mode))
        MODE_UP:   cnt_d = cnt_q + N'(1);
        MODE_DOWN: cnt_d = cnt_q - N'(1);
        MODE_LOAD: cnt_d = load_val;
        MODE_HOLD: cnt_d = cnt_q;
        default:   cnt_d = cnt_q;
      endcase
    end

    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      fifo_out_d = mem[rd_ptr_q];
    end

    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Underflow is applied after the clear so it wins on the same edge.
    if (err_clr) err_d = 1'b0;
    if (fifo_rd && fifo_empty) err_d = 1'b1;
  end

  // Control and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q            <= '0;
      alu_reg_q        <= '0;
      alu_valid_q      <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      fifo_out_q       <= '0;
      fifo_out_valid_q <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      cnt_q            <= cnt_d;
      alu_reg_q        <= alu_reg_d;
      alu_valid_q      <= alu_valid_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      fifo_out_q       <= fifo_out_d;
      fifo_out_valid_q <= fifo_out_valid_d;
      err_q            <= err_d;
    end
  end

  // FIFO storage write port.
  // NOTE: storage has no reset; resetting pointers and count is enough to make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= alu_reg_q;
  end

endmodule

// File: tb/tb_mini_stream_subsystem.sv
// Directed testbench for mini_stream_subsystem (N=8, DEPTH=16, AF_LEVEL=14).
module tb_mini_stream_subsystem;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] cnt_mode;
  logic [7:0] load_val;
  logic [7:0] ext_data;
  logic [2:0] alu_sel;
  logic       fifo_rd;
  logic       err_clr;
  logic [7:0] fifo_out;
  logic       fifo_out_valid;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fifo_almost_full;
  logic [4:0] fifo_count;
  logic       err_underflow;

  int total = 0;
  int bad   = 0;

  mini_stream_subsystem #(.N(8), .DEPTH(16), .AF_LEVEL(14)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .cnt_mode         (cnt_mode),
    .load_val         (load_val),
    .ext_data         (ext_data),
    .alu_sel          (alu_sel),
    .fifo_rd          (fifo_rd),
    .err_clr          (err_clr),
    .fifo_out         (fifo_out),
    .fifo_out_valid   (fifo_out_valid),
    .fifo_empty       (fifo_empty),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .fifo_count       (fifo_count),
    .err_underflow    (err_underflow)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    enable   = 1'b0;
    cnt_mode = 2'b00;
    load_val = 8'h00;
    ext_data = 8'h00;
    alu_sel  = 3'b000;
    fifo_rd  = 1'b0;
    err_clr  = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    enable   = 1'b0;
    cnt_mode = 2'b00;
    load_val = 8'h00;
    ext_data = 8'h00;
    alu_sel  = 3'b000;
    fifo_rd  = 1'b0;
    err_clr  = 1'b0;
    step();
    total++; if (fifo_out !== 8'h00) begin bad++; $display("FAIL reset_out got=%0h exp=0", fifo_out); end
    total++; if (fifo_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", fifo_out_valid); end
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", fifo_empty); end
    total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", fifo_full); end
    total++; if (fifo_almost_full !== 1'b0) begin bad++; $display("FAIL reset_af got=%0b exp=0", fifo_almost_full); end
    total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err_underflow); end
    rst = 1'b1;
  endtask

  // Generate 5,6,... until the FIFO is full; occupancy must saturate at 16.
  task automatic test_fill();
    int exp_cnt;
    do_reset();
    enable   = 1'b1;
    ext_data = 8'd5;
    for (int j = 1; j <= 20; j++) begin
      step();
      exp_cnt = (j - 1 > 16) ? 16 : j - 1;
      total++; if (fifo_count !== 5'(exp_cnt)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", j, fifo_count, exp_cnt); end
      total++; if (fifo_almost_full !== (exp_cnt >= 14)) begin bad++; $display("FAIL fill_af[%0d] got=%0b exp=%0b", j, fifo_almost_full, exp_cnt >= 14); end
      total++; if (fifo_full !== (exp_cnt == 16)) begin bad++; $display("FAIL fill_full[%0d] got=%0b exp=%0b", j, fifo_full, exp_cnt == 16); end
    end
  endtask

  // Continuous reads from full: consecutive values across many pointer wraps.
  task automatic test_drain();
    fifo_rd = 1'b1;
    for (int i = 0; i < 55; i++) begin
      if (i == 40) enable = 1'b0;
      step();
      total++; if (fifo_out !== 8'(5 + i)) begin bad++; $display("FAIL drain_data[%0d] got=%0h exp=%0h", i, fifo_out, 8'(5 + i)); end
      total++; if (fifo_out_valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%0b exp=1", i, fifo_out_valid); end
    end
    fifo_rd = 1'b0;
    step();
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%0b exp=1", fifo_empty); end
    total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", fifo_count); end
    total++; if (fifo_out_valid !== 1'b0) begin bad++; $display("FAIL drain_idle_valid got=%0b exp=0", fifo_out_valid); end
  endtask

  // Runs directly after the drain: FIFO empty, fifo_out holds 0x3B.
  task automatic test_underflow();
    fifo_rd = 1'b1;
    step();
    total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL uf_set got=%0b exp=1", err_underflow); end
    total++; if (fifo_out_valid !== 1'b0) begin bad++; $display("FAIL uf_valid got=%0b exp=0", fifo_out_valid); end
    total++; if (fifo_out !== 8'h3B) begin bad++; $display("FAIL uf_out_held got=%0h exp=3b", fifo_out); end
    total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL uf_count got=%0d exp=0", fifo_count); end
    fifo_rd = 1'b0;
    err_clr = 1'b1;
    step();
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL uf_clear got=%0b exp=0", err_underflow); end
    fifo_rd = 1'b1;
    step();
    total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL uf_priority got=%0b exp=1", err_underflow); end
    fifo_rd = 1'b0;
    step();
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL uf_clear2 got=%0b exp=0", err_underflow); end
    err_clr = 1'b0;
  endtask

  // Counter wrap both ways, plus load and hold; ALU is A+3 throughout.
  task automatic test_wrap();
    logic [1:0] modes [8] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11};
    logic [7:0] exp   [8] = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h03, 8'h02, 8'h02};
    do_reset();
    enable   = 1'b1;
    load_val = 8'hFE;
    ext_data = 8'h03;
    alu_sel  = 3'b000;
    for (int i = 0; i < 8; i++) begin
      cnt_mode = modes[i];
      step();
    end
    enable = 1'b0;
    step();
    total++; if (fifo_count !== 5'd8) begin bad++; $display("FAIL wrap_count got=%0d exp=8", fifo_count); end
    fifo_rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      total++; if (fifo_out !== exp[i]) begin bad++; $display("FAIL wrap_data[%0d] got=%0h exp=%0h", i, fifo_out, exp[i]); end
    end
    fifo_rd = 1'b0;
  endtask

  // A=0x81 held in the counter, B=0x0F, every opcode in turn.
  task automatic test_opcodes();
    logic [7:0] exp [9] = '{8'h0F, 8'h90, 8'h72, 8'h01, 8'h8F, 8'h8E, 8'h7E, 8'h02, 8'h40};
    do_reset();
    enable   = 1'b1;
    cnt_mode = 2'b10;
    load_val = 8'h81;
    ext_data = 8'h0F;
    alu_sel  = 3'b000;
    step();
    cnt_mode = 2'b11;
    for (int op = 0; op < 8; op++) begin
      alu_sel = 3'(op);
      step();
    end
    enable = 1'b0;
    step();
    fifo_rd = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      total++; if (fifo_out !== exp[i]) begin bad++; $display("FAIL op_data[%0d] got=%0h exp=%0h", i, fifo_out, exp[i]); end
    end
    fifo_rd = 1'b0;
  endtask

  // Capture at edge k, counted at k+1, data on fifo_out after k+2.
  task automatic test_latency();
    do_reset();
    enable   = 1'b1;
    ext_data = 8'h33;
    step();
    enable = 1'b0;
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL lat_k_empty got=%0b exp=1", fifo_empty); end
    step();
    total++; if (fifo_count !== 5'd1) begin bad++; $display("FAIL lat_k1_count got=%0d exp=1", fifo_count); end
    fifo_rd = 1'b1;
    step();
    fifo_rd = 1'b0;
    total++; if (fifo_out !== 8'h33) begin bad++; $display("FAIL lat_k2_data got=%0h exp=33", fifo_out); end
    total++; if (fifo_out_valid !== 1'b1) begin bad++; $display("FAIL lat_k2_valid got=%0b exp=1", fifo_out_valid); end
  endtask

  // Reset mid-cycle with 7 entries, a pending ALU result and the error flag set.
  task automatic test_async_reset();
    do_reset();
    fifo_rd = 1'b1;
    step();
    fifo_rd  = 1'b0;
    enable   = 1'b1;
    ext_data = 8'h10;
    for (int i = 0; i < 8; i++) step();
    fifo_rd = 1'b1;
    step();
    fifo_rd = 1'b0;
    enable  = 1'b0;
    total++; if (fifo_count !== 5'd7) begin bad++; $display("FAIL ar_pre_count got=%0d exp=7", fifo_count); end
    total++; if (fifo_out !== 8'h10) begin bad++; $display("FAIL ar_pre_out got=%0h exp=10", fifo_out); end
    total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL ar_pre_err got=%0b exp=1", err_underflow); end
    #3;
    rst = 1'b0;
    #1;
    total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL ar_count got=%0d exp=0", fifo_count); end
    total++; if (fifo_out !== 8'h00) begin bad++; $display("FAIL ar_out got=%0h exp=0", fifo_out); end
    total++; if (fifo_out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%0b exp=0", fifo_out_valid); end
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL ar_empty got=%0b exp=1", fifo_empty); end
    total++; if (fifo_almost_full !== 1'b0) begin bad++; $display("FAIL ar_af got=%0b exp=0", fifo_almost_full); end
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL ar_err got=%0b exp=0", err_underflow); end
    #1;
    rst      = 1'b1;
    enable   = 1'b1;
    ext_data = 8'h20;
    step();
    enable = 1'b0;
    step();
    total++; if (fifo_count !== 5'd1) begin bad++; $display("FAIL ar_post_count got=%0d exp=1", fifo_count); end
    fifo_rd = 1'b1;
    step();
    fifo_rd = 1'b0;
    total++; if (fifo_out !== 8'h20) begin bad++; $display("FAIL ar_post_data got=%0h exp=20", fifo_out); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_underflow();
    test_wrap();
    test_opcodes();
    test_latency();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
